// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done handshake between pipeline control and the muldiv unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, rs1_val, rs2_val, input busy, done, result);
  modport slave  (input start, funct3, rs1_val, rs2_val, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: one bit per cycle shift-add multiply and restoring divide
// over operand magnitudes, with sign correction applied once in FIX.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(ITERS);
  localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [XLEN-1:0]     b_q, result_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                neg_q;
  logic [CntW-1:0]     cnt_q;

  op_e             op_in;
  logic            accept, is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, overflow, special, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] special_acc;

  // Capture-time decode: magnitudes, result sign and fast-path detection.
  always_comb begin
    op_in    = op_e'(bus.funct3);
    accept   = bus.start && (state_q == StIdle || state_q == StDone);
    is_div   = bus.funct3[2];
    is_rem   = bus.funct3[2] & bus.funct3[1];
    a_signed = op_in inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    b_signed = op_in inside {OpMul, OpMulh, OpDiv, OpRem};
    a_neg    = a_signed & bus.rs1_val[XLEN-1];
    b_neg    = b_signed & bus.rs2_val[XLEN-1];
    a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
    b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
    neg_in   = is_rem ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (bus.rs2_val == '0);
    overflow = (op_in inside {OpDiv, OpRem}) && (bus.rs1_val == INT_MIN) &&
               (bus.rs2_val == '1);
    special  = div_zero | overflow;
    // Fast-path results are pre-loaded as {remainder, quotient} so FIX selects them unchanged.
    special_acc = div_zero ? {bus.rs1_val, DIV_ZERO_Q} : {{XLEN{1'b0}}, INT_MIN};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept)                  state_d = special ? StFix : (is_div ? StDiv : StMul);
        else                         state_d = StIdle;
      end
      StMul, StDiv: if (cnt_q == CntLast) state_d = StFix;
      StFix:                         state_d = StDone;
      default:                       state_d = StIdle;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    bus.busy   = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
  end

  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
    // Shifted remainder keeps its carry bit so the trial subtract never overflows.
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res   = '0;
    unique case (op_q)
      OpMul:                      fix_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              fix_res = quo_fix;
      OpRem, OpRemu:              fix_res = rem_fix;
      default:                    fix_res = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OpMul;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      b_q   <= b_mag;
      neg_q <= special ? 1'b0 : neg_in;
      acc_q <= special ? special_acc : {{XLEN{1'b0}}, a_mag};
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        StMul: begin
          acc_q <= {mul_sum, acc_q[XLEN-1:1]};
          cnt_q <= cnt_q + CntW'(1);
        end
        StDiv: begin
          if (div_trial[XLEN]) acc_q <= {acc_q[2*XLEN-2:0], 1'b0};
          else                 acc_q <= {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          cnt_q <= cnt_q + CntW'(1);
        end
        StFix:   result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an expected-result queue popped on each done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int dones = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check(tag, dones, 0);
  endtask

  // mode 0: plain; 1: scramble operands after capture; 2: pulse start while busy.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int mode);
    int lat = 0;
    int busy_n = 0;
    logic got = 1'b0;
    logic [31:0] want;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.rs1_val = a; bus.rs2_val = b;
    exp_q.push_back(exp);
    while (lat < 80 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        if (mode == 1) begin
          bus.rs1_val = ~a; bus.rs2_val = 32'h3; bus.funct3 = ~f;
        end
      end
      if (mode == 2 && lat == 5) begin
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_val = 32'd1; bus.rs2_val = 32'd1;
      end
      if (mode == 2 && lat == 6) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_n, exp_lat - 1);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      if (got) check({tag, "_res"}, bus.result, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.rs1_val = '0; bus.rs2_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    repeat (3) @(posedge clk); #1;
    check("result_hold", bus.result, 32'hFFFF_FFEB);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);

    repeat (2) @(posedge clk);
    run_op("divu_z", 3'b101, 32'd55, 32'd0, 32'hFFFF_FFFF, 2, 0);
    run_op("rem_z", 3'b110, 32'h1234, 32'd0, 32'h0000_1234, 2, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);

    repeat (2) @(posedge clk);
    run_op("capture", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1);
    repeat (2) @(posedge clk);
    run_op("ign_start", 3'b111, 32'd100, 32'd7, 32'd2, 34, 2);
    quiet("ign_single_done", 40);

    // Back-to-back: second start is driven while the first op sits in DONE.
    run_op("b2b_first", 3'b000, 32'd6, 32'd9, 32'd54, 34, 0);
    check("b2b_in_done", 32'(bus.done), 32'd1);
    run_op("b2b_second", 3'b100, 32'd1000, 32'hFFFF_FFFB, 32'hFFFF_FF38, 34, 0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.rs1_val = 32'd999; bus.rs2_val = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    quiet("mid_rst_no_done", 40);
    run_op("post_rst_mul", 3'b000, 32'd3, 32'd5, 32'd15, 34, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
